// File: rtl/ex_hazard_pkg.sv
// Shared ID/EX field positions, controller state encoding and stack-pop word selects.
package ex_hazard_pkg;

    localparam int MR_BIT          = 44;
    localparam int WB_BIT          = 46;
    localparam int WB_ADDR_HI      = 43;
    localparam int WB_ADDR_LO      = 41;
    localparam int JMP_BIT         = 47;
    localparam int SPOP_BIT        = 49;
    localparam int STACK_PC_BIT    = 89;
    localparam int STACK_FLAGS_BIT = 90;

    typedef enum logic [2:0] {
        IDLE,
        POP_HI,
        POP_LO,
        POP_FLG,
        REDIRECT
    } hz_state_t;

    localparam logic [1:0] POP_PC_HI = 2'd0;
    localparam logic [1:0] POP_PC_LO = 2'd1;
    localparam logic [1:0] POP_FLAGS = 2'd2;

    typedef struct packed {
        logic       mr;
        logic       wb;
        logic [2:0] wb_addr;
        logic       jmp;
        logic       spop;
        logic       stack_pc;
        logic       stack_flags;
    } id_ex_fields_t;

endpackage

// File: rtl/ex_hazard_ctrl_unpack.sv
// Combinational extraction of the control fields carried in the ID/EX word.
module id_ex_unpack
    import ex_hazard_pkg::*;
#(
    parameter int W_BUF = 91
) (
    input  logic [W_BUF-1:0] id_ex_buf,
    output id_ex_fields_t    fields
);

    always_comb begin
        fields             = '0;
        fields.mr          = id_ex_buf[MR_BIT];
        fields.wb          = id_ex_buf[WB_BIT];
        fields.wb_addr     = id_ex_buf[WB_ADDR_HI:WB_ADDR_LO];
        fields.jmp         = id_ex_buf[JMP_BIT];
        fields.spop        = id_ex_buf[SPOP_BIT];
        fields.stack_pc    = id_ex_buf[STACK_PC_BIT];
        fields.stack_flags = id_ex_buf[STACK_FLAGS_BIT];
    end

    // Datapath bits travel through the word but are not control fields.
    logic unused_bits;
    assign unused_bits = ^{id_ex_buf[40:0], id_ex_buf[45], id_ex_buf[48], id_ex_buf[88:50]};

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use stalls, taken-jump flushes and the
// multi-cycle RET/RTI stack pop sequence, plus a saturating stall counter.
module ex_hazard_ctrl
    import ex_hazard_pkg::*;
#(
    parameter int W_BUF = 91,
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_BUF-1:0] id_ex_buf,
    input  logic [2:0]       id_src1,
    input  logic [2:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_jmp_taken,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             hold_id_ex,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             pc_from_stack,
    output logic [1:0]       pop_word,
    output logic [W_CNT-1:0] stall_cnt
);

    id_ex_fields_t f;
    hz_state_t     state, state_nx;
    logic          flags_q;
    logic          pop_start, jmp_go, load_use, pop_go;

    id_ex_unpack #(.W_BUF(W_BUF)) u_unpack (
        .id_ex_buf (id_ex_buf),
        .fields    (f)
    );

    function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pop_start = f.mr & f.spop & f.stack_pc;
    assign jmp_go    = f.jmp & ex_jmp_taken;
    assign load_use  = f.mr & f.wb & ~f.stack_pc &
                       ((id_use1 & (id_src1 == f.wb_addr)) |
                        (id_use2 & (id_src2 == f.wb_addr)));

    always_comb begin
        hold_pc       = 1'b0;
        hold_if_id    = 1'b0;
        hold_id_ex    = 1'b0;
        bubble_id_ex  = 1'b0;
        flush_if_id   = 1'b0;
        pc_from_stack = 1'b0;
        pop_word      = POP_PC_HI;
        pop_go        = 1'b0;
        state_nx      = IDLE;
        case (state)
            POP_LO: begin
                {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
                pop_word = POP_PC_LO;
                state_nx = flags_q ? POP_FLG : REDIRECT;
            end
            POP_FLG: begin
                {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
                pop_word = POP_FLAGS;
                state_nx = REDIRECT;
            end
            REDIRECT: begin
                pc_from_stack = 1'b1;
                flush_if_id   = 1'b1;
                bubble_id_ex  = 1'b1;
            end
            // IDLE and the never-entered POP_HI share one decode.
            default: begin
                if (pop_start) begin
                    {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
                    pop_go   = 1'b1;
                    state_nx = POP_LO;
                end else if (jmp_go) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (load_use) begin
                    hold_pc      = 1'b1;
                    hold_if_id   = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
        endcase
        if (!rst_n) begin
            hold_pc       = 1'b0;
            hold_if_id    = 1'b0;
            hold_id_ex    = 1'b0;
            bubble_id_ex  = 1'b0;
            flush_if_id   = 1'b0;
            pc_from_stack = 1'b0;
            pop_word      = POP_PC_HI;
        end
    end

    // Stack_Flags is captured at pop start so later ID/EX changes cannot alter the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flags_q   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (pop_go) flags_q <= f.stack_flags;
            if (hold_pc) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
